// File: rtl/piano_pkg.sv
// Shared definitions for the piano-tiles input path: lane ids, judge states, hit ceiling.
package piano_pkg;
  localparam logic [2:0] LINE_NONE = 3'd0;
  localparam logic [2:0] LINE_1    = 3'd1;
  localparam logic [2:0] LINE_2    = 3'd2;
  localparam logic [2:0] LINE_3    = 3'd3;
  localparam logic [2:0] LINE_4    = 3'd4;

  localparam logic [7:0] HIT_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, JUDGE, CORRECT_WAIT, WRONG_WAIT, RELEASE
  } judge_state_t;

  // pressed is active-high {key3,key2,key1,key0}; key3 has top priority
  function automatic logic [2:0] encode_keys(input logic [3:0] pressed);
    if (pressed[3])      return LINE_1;
    else if (pressed[2]) return LINE_2;
    else if (pressed[1]) return LINE_3;
    else if (pressed[0]) return LINE_4;
    else                 return LINE_NONE;
  endfunction

  function automatic logic multi_pressed(input logic [3:0] pressed);
    return (pressed & (pressed - 4'd1)) != 4'd0;
  endfunction
endpackage

// File: rtl/key_judge_if.sv
// Key/tile/handshake bundle between the judge stage and its game-side neighbours.
interface key_judge_if;
  logic       enable;
  logic       key3, key2, key1, key0;
  logic [2:0] target_line_id;
  logic       correct_input_done, incorrect_input_done;
  logic       correct_input_go, incorrect_input_go;
  logic [2:0] pressed_line_id;
  logic [7:0] hit_count;
  logic       fail, busy;

  modport master (
    output enable, key3, key2, key1, key0, target_line_id,
           correct_input_done, incorrect_input_done,
    input  correct_input_go, incorrect_input_go, pressed_line_id,
           hit_count, fail, busy
  );

  modport slave (
    input  enable, key3, key2, key1, key0, target_line_id,
           correct_input_done, incorrect_input_done,
    output correct_input_go, incorrect_input_go, pressed_line_id,
           hit_count, fail, busy
  );
endinterface

// File: rtl/key_judge_key_stable_timer.sv
// Stable-window counter shared by the press debounce and the release wait.
module key_stable_timer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (count_en)  cnt <= cnt + CNT_W'(1);
  end

  // High when the next counted cycle brings the count to DEBOUNCE_CYCLES-1
  assign expired = (cnt == LAST);
endmodule

// File: rtl/key_judge.sv
// Debounces lane keys, judges the press against the lowest tile, runs one go/done handshake per press.
// Optional build macro: KEY_JUDGE_MULTI_KEY_FAIL_EN (multi-key presses judged wrong, set changes restart debounce).
module key_judge
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  key_judge_if.slave  bus
);
  judge_state_t state, state_nxt;
  logic [3:0] pressed;
  logic [2:0] enc, cand, pid;
  logic [7:0] hit;
  logic       fail_q;
  logic       t_clear, t_en, t_expired;
  logic       load_cand, load_pid, clr_pid, inc_hit, set_fail, correct_hit;
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
  logic [3:0] cand_set;
`endif

  assign pressed = ~{bus.key3, bus.key2, bus.key1, bus.key0};
  assign enc     = encode_keys(pressed);

  key_stable_timer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clock(clock), .reset(reset), .clear(t_clear), .count_en(t_en), .expired(t_expired)
  );

  always_comb begin
    state_nxt = state;
    t_clear   = 1'b1;
    t_en      = 1'b0;
    load_cand = 1'b0;
    load_pid  = 1'b0;
    clr_pid   = 1'b0;
    inc_hit   = 1'b0;
    set_fail  = 1'b0;
    correct_hit = (cand == bus.target_line_id) && (bus.target_line_id != LINE_NONE);
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
    if (multi_pressed(pressed)) correct_hit = 1'b0;
`endif
    case (state)
      IDLE: if (bus.enable && !fail_q && enc != LINE_NONE) begin
        load_cand = 1'b1;
        state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        t_clear = 1'b0;
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
        if (!bus.enable || enc == LINE_NONE) state_nxt = IDLE;
        else if (pressed != cand_set) begin
          load_cand = 1'b1;
          t_clear   = 1'b1;
        end else begin
          t_en = 1'b1;
          if (t_expired) state_nxt = JUDGE;
        end
`else
        if (!bus.enable || enc != cand) state_nxt = IDLE;
        else begin
          t_en = 1'b1;
          if (t_expired) state_nxt = JUDGE;
        end
`endif
      end
      JUDGE: begin
        load_pid  = 1'b1;
        state_nxt = correct_hit ? CORRECT_WAIT : WRONG_WAIT;
      end
      CORRECT_WAIT: if (bus.correct_input_done) begin
        inc_hit   = 1'b1;
        state_nxt = RELEASE;
      end
      WRONG_WAIT: if (bus.incorrect_input_done) begin
        set_fail  = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Any key still down restarts the window, so a held key never re-triggers
        t_clear = |pressed;
        t_en    = ~|pressed;
        if (~|pressed && t_expired) begin
          clr_pid   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cand   <= LINE_NONE;
      pid    <= LINE_NONE;
      hit    <= '0;
      fail_q <= 1'b0;
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
      cand_set <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (load_cand) cand <= enc;
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
      if (load_cand) cand_set <= pressed;
`endif
      if (load_pid)     pid <= cand;
      else if (clr_pid) pid <= LINE_NONE;
      if (inc_hit && hit != HIT_MAX) hit <= hit + 8'd1;
      if (set_fail) fail_q <= 1'b1;
    end
  end

  assign bus.correct_input_go   = (state == CORRECT_WAIT);
  assign bus.incorrect_input_go = (state == WRONG_WAIT);
  assign bus.pressed_line_id    = pid;
  assign bus.hit_count          = hit;
  assign bus.fail               = fail_q;
  assign bus.busy               = (state != IDLE);
endmodule

// File: tb/tb_key_judge.sv
// Directed bench for key_judge with a 4-cycle debounce window: per-cycle vector table plus corner sequences.
module tb_key_judge;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  key_judge_if bus();
  key_judge #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    logic       rst, en;
    logic [3:0] keys;
    logic [2:0] tgt;
    logic       cd, idn;
    logic       cgo, igo;
    logic [2:0] pid;
    logic [7:0] hit;
    logic       fail, busy;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;
  int c_rise, i_rise, go_age;
  logic prev_c, prev_i, auto_done;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic rst, en, input logic [3:0] keys, input logic [2:0] tgt,
                     input logic cd, idn, cgo, igo, input logic [2:0] pid,
                     input logic [7:0] hit, input logic fail, busy);
    vec_t v;
    v.rst = rst; v.en = en; v.keys = keys; v.tgt = tgt; v.cd = cd; v.idn = idn;
    v.cgo = cgo; v.igo = igo; v.pid = pid; v.hit = hit; v.fail = fail; v.busy = busy;
    vecs.push_back(v);
  endtask

  // One clock with keys k; optional auto responder returns done after go was seen twice
  task automatic step(input logic [3:0] k);
    {bus.key3, bus.key2, bus.key1, bus.key0} = k;
    if (auto_done) begin
      bus.correct_input_done   = bus.correct_input_go   && go_age >= 2;
      bus.incorrect_input_done = bus.incorrect_input_go && go_age >= 2;
    end
    @(posedge clock); #1;
    if (bus.correct_input_go && !prev_c)   c_rise++;
    if (bus.incorrect_input_go && !prev_i) i_rise++;
    prev_c = bus.correct_input_go;
    prev_i = bus.incorrect_input_go;
    go_age = (bus.correct_input_go || bus.incorrect_input_go) ? go_age + 1 : 0;
  endtask

  task automatic steps(input logic [3:0] k, input int n);
    for (int j = 0; j < n; j++) step(k);
  endtask

  task automatic do_reset(input logic [2:0] tgt);
    reset = 1'b1;
    bus.correct_input_done = 1'b0;
    bus.incorrect_input_done = 1'b0;
    bus.enable = 1'b1;
    bus.target_line_id = tgt;
    steps(4'hF, 2);
    reset = 1'b0;
    c_rise = 0; i_rise = 0; go_age = 0; prev_c = 1'b0; prev_i = 1'b0;
  endtask

  initial begin
    localparam logic [3:0] F = 4'hF;
    auto_done = 1'b0;
    bus.enable = 1'b0;
    {bus.key3, bus.key2, bus.key1, bus.key0} = F;
    bus.target_line_id = 3'd0;
    bus.correct_input_done = 1'b0;
    bus.incorrect_input_done = 1'b0;
    c_rise = 0; i_rise = 0; go_age = 0; prev_c = 1'b0; prev_i = 1'b0;

    // rst en keys tgt cd id | cgo igo pid hit fail busy
    add(1,0,F,0,0,0, 0,0,0,0,0,0);
    add(1,0,F,0,0,0, 0,0,0,0,0,0);
    // correct hit: key2 low 10 cycles, target 2, done on 4th go cycle
    for (int i = 0; i < 4; i++) add(0,1,4'b1011,2,0,0, 0,0,0,0,0,1);
    add(0,1,4'b1011,2,0,0, 1,0,2,0,0,1);
    add(0,1,4'b1011,2,0,1, 1,0,2,0,0,1);   // stray incorrect_done ignored
    add(0,1,4'b1011,2,0,0, 1,0,2,0,0,1);
    add(0,1,4'b1011,2,0,0, 1,0,2,0,0,1);
    add(0,1,4'b1011,2,1,0, 0,0,2,1,0,1);
    add(0,1,4'b1011,2,0,0, 0,0,2,1,0,1);
    add(0,1,F,2,0,0, 0,0,2,1,0,1);
    add(0,1,F,2,0,0, 0,0,2,1,0,1);
    add(0,1,F,2,0,0, 0,0,0,1,0,0);
    add(0,1,F,2,0,0, 0,0,0,1,0,0);
    // reset clears hit count; then wrong key: key0 low, target 1
    add(1,1,F,1,0,0, 0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,4'b1110,1,0,0, 0,0,0,0,0,1);
    add(0,1,4'b1110,1,0,0, 0,1,4,0,0,1);
    add(0,1,4'b1110,1,1,0, 0,1,4,0,0,1);   // stray correct_done ignored
    add(0,1,4'b1110,1,0,1, 0,0,4,0,1,1);
    add(0,1,F,1,0,0, 0,0,4,0,1,1);
    add(0,1,F,1,0,0, 0,0,4,0,1,1);
    add(0,1,F,1,0,0, 0,0,0,0,1,0);
    // fail is sticky: a correct press is not accepted
    for (int i = 0; i < 6; i++) add(0,1,4'b0111,1,0,0, 0,0,0,0,1,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.enable = vecs[i].en;
      {bus.key3, bus.key2, bus.key1, bus.key0} = vecs[i].keys;
      bus.target_line_id = vecs[i].tgt;
      bus.correct_input_done = vecs[i].cd;
      bus.incorrect_input_done = vecs[i].idn;
      @(posedge clock); #1;
      check($sformatf("v%0d.cgo", i),  bus.correct_input_go,   vecs[i].cgo);
      check($sformatf("v%0d.igo", i),  bus.incorrect_input_go, vecs[i].igo);
      check($sformatf("v%0d.pid", i),  bus.pressed_line_id,    vecs[i].pid);
      check($sformatf("v%0d.hit", i),  bus.hit_count,          vecs[i].hit);
      check($sformatf("v%0d.fail", i), bus.fail,               vecs[i].fail);
      check($sformatf("v%0d.busy", i), bus.busy,               vecs[i].busy);
    end

    // bounce: 2 low, 1 high, 2 low never judges
    auto_done = 1'b1;
    do_reset(3'd3);
    steps(4'b1101, 2); steps(F, 1); steps(4'b1101, 2); steps(F, 3);
    check("bounce.go",   c_rise + i_rise, 0);
    check("bounce.busy", bus.busy, 0);
    steps(4'b1101, 5); steps(F, 10);
    check("bounce_hold.cgo", c_rise, 1);
    check("bounce_hold.igo", i_rise, 0);
    check("bounce_hold.hit", bus.hit_count, 1);

    // held key: exactly one handshake, release window of 3 high cycles
    do_reset(3'd1);
    steps(4'b0111, 100);
    check("held.cgo", c_rise, 1);
    check("held.busy_held", bus.busy, 1);
    steps(F, 2);
    check("held.busy_rel2", bus.busy, 1);
    steps(F, 2);
    check("held.busy_rel4", bus.busy, 0);
    check("held.hit", bus.hit_count, 1);

    // saturation
    do_reset(3'd1);
    for (int p = 0; p < 255; p++) begin steps(4'b0111, 5); steps(F, 6); end
    check("sat.hit255", bus.hit_count, 255);
    steps(4'b0111, 5); steps(F, 6);
    check("sat.hit_hold", bus.hit_count, 255);
    check("sat.gos", c_rise, 256);

    // two keys together, target 1
    do_reset(3'd1);
    steps(4'b0110, 5); steps(F, 6);
`ifdef KEY_JUDGE_MULTI_KEY_FAIL_EN
    check("multi.igo", i_rise, 1);
    check("multi.cgo", c_rise, 0);
    check("multi.fail", bus.fail, 1);
`else
    check("multi.cgo", c_rise, 1);
    check("multi.igo", i_rise, 0);
    check("multi.hit", bus.hit_count, 1);
`endif

    // reset mid-handshake after one scored hit
    do_reset(3'd1);
    steps(4'b0111, 5); steps(F, 6);
    check("rst.pre_hit", bus.hit_count, 1);
    auto_done = 1'b0;
    steps(4'b0111, 5);
    check("rst.in_wait", bus.correct_input_go, 1);
    reset = 1'b1;
    step(4'b0111);
    check("rst.cgo",  bus.correct_input_go, 0);
    check("rst.igo",  bus.incorrect_input_go, 0);
    check("rst.pid",  bus.pressed_line_id, 0);
    check("rst.hit",  bus.hit_count, 0);
    check("rst.busy", bus.busy, 0);
    reset = 1'b0;
    bus.correct_input_done = 1'b1;
    steps(F, 2);
    bus.correct_input_done = 1'b0;
    check("rst.late_done_hit", bus.hit_count, 0);
    check("rst.late_done_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
